// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Direct-mapped table of saturating counters predicting
//                conditional-branch direction, with RV32 branch resolution
//                and saturating accuracy statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
    parameter int ENTRIES   = 64,
    parameter int PC_WIDTH  = 32,
    parameter int CTR_BITS  = 2,
    parameter int CTR_INIT  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // lookup port
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    // resolution port
    input  logic                 res_valid,
    input  logic [PC_WIDTH-1:0]  res_pc,
    input  logic [2:0]           res_type,
    input  logic                 res_zero,
    input  logic                 res_lt,
    input  logic                 res_ltu,
    input  logic                 res_pred,
    output logic                 res_out_valid,
    output logic                 res_taken,
    output logic                 mispredict,
    output logic                 illegal_type,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [2:0]          C_BEQ      = 3'b000;
    localparam logic [2:0]          C_BNE      = 3'b001;
    localparam logic [2:0]          C_BLT      = 3'b100;
    localparam logic [2:0]          C_BGE      = 3'b101;
    localparam logic [2:0]          C_BLTU     = 3'b110;
    localparam logic [2:0]          C_BGEU     = 3'b111;
    localparam logic [CTR_BITS-1:0] C_CTR_INIT = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_BITS-1:0] C_CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CTR_BITS-1:0]  table_q [ENTRIES];

    logic                 pred_out_valid_q;
    logic                 pred_taken_q, pred_taken_d;
    logic                 res_out_valid_q, res_out_valid_d;
    logic                 res_taken_q, res_taken_d;
    logic                 mispredict_q, mispredict_d;
    logic                 illegal_type_q, illegal_type_d;
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    // ------------------------------------------------------------------------
    // Indexing: word-aligned PCs, so bits [1:0] never select an entry
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]     w_pred_idx;
    logic [IDX_W-1:0]     w_res_idx;
    logic                 w_unused_pc;

    assign w_pred_idx  = pred_pc[IDX_W+1:2];
    assign w_res_idx   = res_pc[IDX_W+1:2];
    assign w_unused_pc = ^{pred_pc[PC_WIDTH-1:IDX_W+2], pred_pc[1:0],
                           res_pc[PC_WIDTH-1:IDX_W+2],  res_pc[1:0]};

    // ------------------------------------------------------------------------
    // Branch outcome decode
    // ------------------------------------------------------------------------
    logic w_legal;
    logic w_taken;

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (res_type)
            C_BEQ:   w_taken = res_zero;
            C_BNE:   w_taken = ~res_zero;
            C_BLT:   w_taken = res_lt;
            C_BGE:   w_taken = ~res_lt;
            C_BLTU:  w_taken = res_ltu;
            C_BGEU:  w_taken = ~res_ltu;
            default: w_legal = 1'b0;
        endcase
    end

    logic w_update;
    logic w_mispredict;

    assign w_update     = res_valid & w_legal;
    assign w_mispredict = w_update & (w_taken ^ res_pred);

    // ------------------------------------------------------------------------
    // Saturating counter next value for the resolving entry
    // ------------------------------------------------------------------------
    logic [CTR_BITS-1:0] w_ctr_cur;
    logic [CTR_BITS-1:0] w_ctr_nxt;

    assign w_ctr_cur = table_q[w_res_idx];

    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != C_CTR_MAX) begin
                w_ctr_nxt = w_ctr_cur + 1'b1;
            end
        end else begin
            if (w_ctr_cur != '0) begin
                w_ctr_nxt = w_ctr_cur - 1'b1;
            end
        end
    end

    // Table write; lookup reads table_q, so same-index traffic is read-before-write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= C_CTR_INIT;
            end
        end else if (w_update) begin
            table_q[w_res_idx] <= w_ctr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------------
    always_comb begin
        pred_taken_d = pred_taken_q;
        if (pred_valid) begin
            pred_taken_d = table_q[w_pred_idx][CTR_BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
        end else begin
            pred_out_valid_q <= pred_valid;
            pred_taken_q     <= pred_taken_d;
        end
    end

    // ------------------------------------------------------------------------
    // Resolution path and statistics
    // ------------------------------------------------------------------------
    always_comb begin
        res_out_valid_d    = res_valid;
        res_taken_d        = w_update & w_taken;
        mispredict_d       = w_mispredict;
        illegal_type_d     = res_valid & ~w_legal;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (w_update && (branch_count_q != C_CNT_MAX)) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (w_mispredict && (mispredict_count_q != C_CNT_MAX)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_out_valid_q    <= 1'b0;
            res_taken_q        <= 1'b0;
            mispredict_q       <= 1'b0;
            illegal_type_q     <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            res_out_valid_q    <= res_out_valid_d;
            res_taken_q        <= res_taken_d;
            mispredict_q       <= mispredict_d;
            illegal_type_q     <= illegal_type_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pred_out_valid   = pred_out_valid_q;
    assign pred_taken       = pred_taken_q;
    assign res_out_valid    = res_out_valid_q;
    assign res_taken        = res_taken_q;
    assign mispredict       = mispredict_q;
    assign illegal_type     = illegal_type_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Directed self-checking bench for branch_predictor_bht.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

    localparam int PC_WIDTH  = 32;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 pred_valid;
    logic [PC_WIDTH-1:0]  pred_pc;
    logic                 pred_out_valid;
    logic                 pred_taken;
    logic                 res_valid;
    logic [PC_WIDTH-1:0]  res_pc;
    logic [2:0]           res_type;
    logic                 res_zero;
    logic                 res_lt;
    logic                 res_ltu;
    logic                 res_pred;
    logic                 res_out_valid;
    logic                 res_taken;
    logic                 mispredict;
    logic                 illegal_type;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    int n_checks;
    int n_fail;

    branch_predictor_bht #(
        .ENTRIES   (64),
        .PC_WIDTH  (PC_WIDTH),
        .CTR_BITS  (2),
        .CTR_INIT  (1),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_out_valid   (pred_out_valid),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_type         (res_type),
        .res_zero         (res_zero),
        .res_lt           (res_lt),
        .res_ltu          (res_ltu),
        .res_pred         (res_pred),
        .res_out_valid    (res_out_valid),
        .res_taken        (res_taken),
        .mispredict       (mispredict),
        .illegal_type     (illegal_type),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        res_zero   = 1'b0;
        res_lt     = 1'b0;
        res_ltu    = 1'b0;
        res_pred   = 1'b0;
    endtask

    task automatic lookup(input logic [PC_WIDTH-1:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
    endtask

    task automatic resolve(input logic [PC_WIDTH-1:0] pc, input logic [2:0] t,
                           input logic z, input logic lt, input logic ltu, input logic p);
        res_valid = 1'b1;
        res_pc    = pc;
        res_type  = t;
        res_zero  = z;
        res_lt    = lt;
        res_ltu   = ltu;
        res_pred  = p;
    endtask

    task automatic chk_res(input string tag, input logic v, input logic t,
                           input logic m, input logic il);
        chk({tag, ".valid"},   32'(res_out_valid), 32'(v));
        chk({tag, ".taken"},   32'(res_taken),     32'(t));
        chk({tag, ".misp"},    32'(mispredict),    32'(m));
        chk({tag, ".illegal"}, 32'(illegal_type),  32'(il));
    endtask

    task automatic chk_cnt(input string tag, input int b, input int m);
        chk({tag, ".branch_count"},     32'(branch_count),     32'(b));
        chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(m));
    endtask

    task automatic chk_pred(input string tag, input logic v, input logic t);
        chk({tag, ".pred_valid"}, 32'(pred_out_valid), 32'(v));
        chk({tag, ".pred_taken"}, 32'(pred_taken),     32'(t));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        pred_pc  = '0;
        res_pc   = '0;
        res_type = 3'b000;

        // Reset with requests present: they must be discarded
        rst_n = 1'b0;
        lookup(32'h100);
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_pred("reset", 1'b0, 1'b0);
        chk_res("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0);

        // First lookup after reset sees weakly-not-taken
        rst_n = 1'b1;
        idle();
        lookup(32'h100);
        tick();
        chk_pred("first_lookup", 1'b1, 1'b0);
        chk_res("idle_res", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("discarded", 0, 0);

        // Two taken BEQ predicted not-taken
        idle();
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_pred("no_lookup", 1'b0, 1'b0);
        chk_res("beq1", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_res("beq2", 1'b1, 1'b1, 1'b1, 1'b0);
        chk_cnt("beq2", 2, 2);
        idle();
        lookup(32'h100);
        tick();
        chk_pred("after_beq", 1'b1, 1'b1);
        chk_res("res_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        tick();
        chk_pred("hold", 1'b0, 1'b1);

        // Five not-taken BGEU: 3 -> 0, saturating
        resolve(32'h100, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        chk_res("bgeu_nt", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt("bgeu_nt", 7, 2);
        idle();
        lookup(32'h200);
        tick();
        chk_pred("sat_low", 1'b1, 1'b0);

        // Three taken BGEU: 0 -> 3, then BLT taken holds at 3
        idle();
        resolve(32'h100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk_res("bgeu_t", 1'b1, 1'b1, 1'b0, 1'b0);
        resolve(32'h100, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_res("blt_t", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_cnt("sat_high", 11, 2);
        idle();
        lookup(32'h200);
        tick();
        chk_pred("alias", 1'b1, 1'b1);

        // Remaining branch types, all predicted taken
        idle();
        resolve(32'h80, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_res("bne", 1'b1, 1'b1, 1'b0, 1'b0);
        resolve(32'h80, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_res("bltu", 1'b1, 1'b1, 1'b0, 1'b0);
        resolve(32'h80, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_res("bge", 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(32'h80, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk_res("blt_nt", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_cnt("types", 15, 4);

        // Same-cycle lookup and update: read-before-write
        idle();
        resolve(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup(32'h40);
        tick();
        chk_pred("rbw_same", 1'b1, 1'b0);
        chk_res("rbw_res", 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        lookup(32'h40);
        tick();
        chk_pred("rbw_next", 1'b1, 1'b1);

        // Illegal types leave table and statistics untouched
        idle();
        resolve(32'h40, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_res("illegal010", 1'b1, 1'b0, 1'b0, 1'b1);
        resolve(32'h40, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_res("illegal011", 1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt("illegal", 16, 5);
        idle();
        lookup(32'h40);
        tick();
        chk_pred("illegal_tbl", 1'b1, 1'b1);

        // Drive branch_count to all-ones, then one more legal branch
        idle();
        resolve(32'h300, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (239) tick();
        chk_cnt("cnt_full", 255, 5);
        tick();
        chk_cnt("cnt_sat", 255, 5);

        // Reset in the cycle after a resolution drops the in-flight result
        resolve(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_res("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        rst_n = 1'b0;
        tick();
        chk_res("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("mid_rst", 0, 0);
        rst_n = 1'b1;
        lookup(32'h40);
        tick();
        chk_pred("rst_0x40", 1'b1, 1'b0);
        lookup(32'h100);
        tick();
        chk_pred("rst_0x100", 1'b1, 1'b0);

        // Counter is exactly 1 after reset: one taken makes it predict taken
        idle();
        resolve(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        lookup(32'h40);
        tick();
        chk_pred("rst_init", 1'b1, 1'b1);
        chk_cnt("post_rst", 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
